// File: rtl/serial_sub8_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states,
// the default operand width and the bit-counter sizing helper.
package sub_pkg;

   // Default operand/result width in bits.
   localparam int DEFAULT_WIDTH = 8;

   // Controller states: waiting, shifting bits, presenting a result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit counter width: enough to count 0..WIDTH-1.
   function automatic int cntWidth(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_sub8_fs.sv
// Single-bit full subtractor cell: d = a - b - bin with borrow-out.
module fs (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference is the parity of the three inputs; a borrow is needed
   // whenever the subtracted bits outweigh the minuend bit.
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~a & bin) | (b & bin);
   end

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial ripple-borrow subtractor. One fs cell consumes one bit of the
// captured operands per clock, LSB first, with the borrow kept in a register.
// A start/ready/valid handshake lets a controller chain operations
// back to back by holding start while the result is presented.
import sub_pkg::*;

module serial_sub8 #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = cntWidth(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_xShift;
   logic [WIDTH-1:0] r_yShift;
   logic [WIDTH-1:0] r_resShift;
   logic             r_borrow;
   logic [CW-1:0]    r_bitCnt;
   logic             r_xMsb;
   logic             r_yMsb;
   logic [WIDTH-1:0] r_d;
   logic             r_bout;
   logic             r_ovf;

   logic             w_fsDiff;
   logic             w_fsBorrow;
   logic [WIDTH-1:0] w_nextRes;
   logic             w_accept;
   logic             w_lastBit;

   // The one and only subtractor cell, fed from the operand LSBs.
   fs u_fs (
      .a    (r_xShift[0]),
      .b    (r_yShift[0]),
      .bin  (r_borrow),
      .d    (w_fsDiff),
      .bout (w_fsBorrow)
   );

   // Handshake decode and the result register after this cycle's shift.
   // ready covers DONE so a held start chains straight into the next RUN.
   always_comb begin
      ready     = (r_state == IDLE) || (r_state == DONE);
      valid     = (r_state == DONE);
      w_accept  = ready && start;
      w_lastBit = (r_state == RUN) && (r_bitCnt == LAST_BIT);
      w_nextRes = {w_fsDiff, r_resShift[WIDTH-1:1]};
   end

   // Controller: accept in IDLE/DONE, shift WIDTH bits in RUN, then show
   // the result for exactly one cycle. start in RUN is simply not looked at.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    r_state <= w_accept ? RUN : IDLE;
            RUN:     r_state <= w_lastBit ? DONE : RUN;
            DONE:    r_state <= w_accept ? RUN : IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Datapath: operands and borrow-in are captured on accept; during RUN
   // the operands shift right while difference bits enter the result at
   // the top, so after WIDTH shifts the result is in natural bit order.
   // The operand sign bits are kept aside because the shifters lose them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_xShift   <= '0;
         r_yShift   <= '0;
         r_resShift <= '0;
         r_borrow   <= 1'b0;
         r_bitCnt   <= '0;
         r_xMsb     <= 1'b0;
         r_yMsb     <= 1'b0;
      end else if (w_accept) begin
         r_xShift <= x;
         r_yShift <= y;
         r_borrow <= bin;
         r_bitCnt <= '0;
         r_xMsb   <= x[WIDTH-1];
         r_yMsb   <= y[WIDTH-1];
      end else if (r_state == RUN) begin
         r_xShift   <= r_xShift >> 1;
         r_yShift   <= r_yShift >> 1;
         r_resShift <= w_nextRes;
         r_borrow   <= w_fsBorrow;
         r_bitCnt   <= r_bitCnt + CW'(1);
      end
   end

   // Result registers change only on the edge that enters DONE, so the
   // outputs hold the previous answer through IDLE and the next RUN.
   // Overflow: operand signs differ and the result sign differs from x.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_d    <= '0;
         r_bout <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_lastBit) begin
         r_d    <= w_nextRes;
         r_bout <= w_fsBorrow;
         r_ovf  <= (r_xMsb != r_yMsb) && (w_fsDiff != r_xMsb);
      end
   end

   // Outputs come straight from registers; nothing combinational from inputs.
   always_comb begin
      d    = r_d;
      bout = r_bout;
      ovf  = r_ovf;
   end

endmodule
